// File: rtl/fpnew_i2fcast_pipe.sv
// Integer-to-float cast, 2-stage pipeline: S1 extend/abs/lzc, S2 normalise/round/pack.
// Valid/ready handshake with flush; tag travels alongside each operation.
module fpnew_i2fcast_pipe #(
  parameter int unsigned DstFpFormat  = 0,        // 0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT
  parameter logic [3:0]  IntFmtConfig = 4'b1111,  // bit i enables INT8<<i
  parameter type         TagType      = logic,
  localparam int unsigned EXP_BITS  = (DstFpFormat == 1) ? 11 :
                                      (DstFpFormat == 2 || DstFpFormat == 3) ? 5 : 8,
  localparam int unsigned MAN_BITS  = (DstFpFormat == 0) ? 23 : (DstFpFormat == 1) ? 52 :
                                      (DstFpFormat == 2) ? 10 : (DstFpFormat == 3) ? 2 : 7,
  localparam int unsigned DST_WIDTH = 1 + EXP_BITS + MAN_BITS,
  localparam int unsigned SRC_WIDTH = IntFmtConfig[3] ? 64 : IntFmtConfig[2] ? 32 :
                                      IntFmtConfig[1] ? 16 : 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [SRC_WIDTH-1:0] operands_i,
  input  logic [2:0]           rnd_mode_i,
  input  logic                 op_mod_i,
  input  logic [1:0]           int_fmt_i,
  input  TagType               tag_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 flush_i,
  output logic [DST_WIDTH-1:0] result_o,
  output logic [4:0]           status_o,
  output logic                 extension_bit_o,
  output TagType               tag_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
);

  localparam int unsigned LZW     = (SRC_WIDTH > 1) ? $clog2(SRC_WIDTH) : 1;
  localparam int unsigned SHW     = LZW;
  localparam int unsigned EXPW    = ((EXP_BITS > LZW) ? EXP_BITS : LZW) + 2;
  localparam int unsigned BIAS    = (2 ** (EXP_BITS - 1)) - 1;
  localparam int unsigned MAX_EXP = (2 ** EXP_BITS) - 1;
  localparam int unsigned MW      = (SRC_WIDTH > MAN_BITS + 3) ? SRC_WIDTH : MAN_BITS + 3;
  localparam int unsigned PW      = EXPW + MAN_BITS;
  localparam int unsigned SH8     = (SRC_WIDTH > 8)  ? SRC_WIDTH - 8  : 0;
  localparam int unsigned SH16    = (SRC_WIDTH > 16) ? SRC_WIDTH - 16 : 0;
  localparam int unsigned SH32    = (SRC_WIDTH > 32) ? SRC_WIDTH - 32 : 0;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  // Pipeline registers
  logic                 s1_vld_q, s1_vld_d;
  logic                 s1_sign_q, s1_sign_d;
  logic                 s1_zero_q, s1_zero_d;
  logic [SRC_WIDTH-1:0] s1_abs_q, s1_abs_d;
  logic [LZW-1:0]       s1_lzc_q, s1_lzc_d;
  logic [2:0]           s1_rnd_q, s1_rnd_d;
  TagType               s1_tag_q, s1_tag_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [DST_WIDTH-1:0] result_q, result_d;
  logic [4:0]           status_q, status_d;
  TagType               tag_q, tag_d;

  logic s2_rdy_c, in_accept_c, s1_adv_c;

  assign s2_rdy_c        = ~s2_vld_q | out_ready_i;
  assign in_ready_o      = ~s1_vld_q | s2_rdy_c;
  assign in_accept_c     = in_valid_i & in_ready_o & ~flush_i;
  assign s1_adv_c        = s1_vld_q & s2_rdy_c;
  assign result_o        = result_q;
  assign status_o        = status_q;
  assign tag_o           = tag_q;
  assign out_valid_o     = s2_vld_q;
  assign busy_o          = s1_vld_q | s2_vld_q;
  assign extension_bit_o = 1'b1;

  // S1: sign/zero extension by source width, then magnitude and leading-zero count
  logic [SHW-1:0]       sh_amt;
  logic [SRC_WIDTH-1:0] shl_val, ext_val, abs_val;
  logic                 sign_val;
  logic [LZW-1:0]       lzc_val;

  always_comb begin
    sh_amt = '0;
    case (int_fmt_i)
      2'd0:    sh_amt = SHW'(SH8);
      2'd1:    sh_amt = SHW'(SH16);
      2'd2:    sh_amt = SHW'(SH32);
      default: sh_amt = '0;
    endcase
    shl_val  = operands_i << sh_amt;
    ext_val  = op_mod_i ? (shl_val >> sh_amt) : SRC_WIDTH'($signed(shl_val) >>> sh_amt);
    sign_val = ~op_mod_i & ext_val[SRC_WIDTH-1];
    abs_val  = sign_val ? -ext_val : ext_val;
  end

  always_comb begin
    lzc_val = '0;
    for (int unsigned i = 0; i < SRC_WIDTH; i++) begin
      if (abs_val[i]) lzc_val = LZW'(SRC_WIDTH - 1 - i);
    end
  end

  // S2: normalise, round on the packed {exp,frac} so a mantissa carry bumps the exponent
  logic [SRC_WIDTH-1:0] mant;
  logic [MW-1:0]        mant_ext;
  logic [MAN_BITS-1:0]  frac;
  logic                 rnd_bit, sticky, round_up, inexact, to_inf, ovf;
  logic [EXPW-1:0]      exp_b, exp_r;
  logic [PW-1:0]        rounded;

  always_comb begin
    mant     = s1_abs_q << s1_lzc_q;
    mant_ext = MW'(mant) << (MW - SRC_WIDTH);
    frac     = mant_ext[MW-2 -: MAN_BITS];
    rnd_bit  = mant_ext[MW-2-MAN_BITS];
    sticky   = |mant_ext[MW-3-MAN_BITS:0];
    inexact  = rnd_bit | sticky;
    exp_b    = EXPW'(SRC_WIDTH - 1) - EXPW'(s1_lzc_q) + EXPW'(BIAS);
    round_up = 1'b0;
    case (s1_rnd_q)
      RNE:     round_up = rnd_bit & (sticky | frac[0]);
      RTZ:     round_up = 1'b0;
      RDN:     round_up = inexact & s1_sign_q;
      RUP:     round_up = inexact & ~s1_sign_q;
      RMM:     round_up = rnd_bit;
      default: round_up = 1'b0;
    endcase
    rounded = {exp_b, frac} + PW'(round_up);
    exp_r   = rounded[PW-1 -: EXPW];
    ovf     = exp_r >= EXPW'(MAX_EXP);
    to_inf  = (s1_rnd_q == RNE) | (s1_rnd_q == RMM) |
              ((s1_rnd_q == RUP) & ~s1_sign_q) | ((s1_rnd_q == RDN) & s1_sign_q);
  end

  // Next-state for both stages; flush kills valids and blocks the accept
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_sign_d = s1_sign_q;
    s1_zero_d = s1_zero_q;
    s1_abs_d  = s1_abs_q;
    s1_lzc_d  = s1_lzc_q;
    s1_rnd_d  = s1_rnd_q;
    s1_tag_d  = s1_tag_q;
    s2_vld_d  = s2_vld_q;
    result_d  = result_q;
    status_d  = status_q;
    tag_d     = tag_q;

    if (in_accept_c) begin
      s1_sign_d = sign_val;
      s1_zero_d = ~|abs_val;
      s1_abs_d  = abs_val;
      s1_lzc_d  = lzc_val;
      s1_rnd_d  = rnd_mode_i;
      s1_tag_d  = tag_i;
    end

    if (s1_adv_c) begin
      tag_d = s1_tag_q;
      if (s1_zero_q) begin
        result_d = '0;
        status_d = '0;
      end else if (ovf) begin
        result_d = to_inf ? {s1_sign_q, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}}
                          : {s1_sign_q, {(EXP_BITS-1){1'b1}}, 1'b0, {MAN_BITS{1'b1}}};
        status_d = 5'b00101;
      end else begin
        result_d = {s1_sign_q, exp_r[EXP_BITS-1:0], rounded[MAN_BITS-1:0]};
        status_d = {4'b0000, inexact};
      end
    end

    if (flush_i) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end else begin
      if (in_accept_c)   s1_vld_d = 1'b1;
      else if (s1_adv_c) s1_vld_d = 1'b0;
      if (s2_rdy_c)      s2_vld_d = s1_vld_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_abs_q  <= '0;
      s1_lzc_q  <= '0;
      s1_rnd_q  <= '0;
      s1_tag_q  <= '0;
      s2_vld_q  <= 1'b0;
      result_q  <= '0;
      status_q  <= '0;
      tag_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_sign_q <= s1_sign_d;
      s1_zero_q <= s1_zero_d;
      s1_abs_q  <= s1_abs_d;
      s1_lzc_q  <= s1_lzc_d;
      s1_rnd_q  <= s1_rnd_d;
      s1_tag_q  <= s1_tag_d;
      s2_vld_q  <= s2_vld_d;
      result_q  <= result_d;
      status_q  <= status_d;
      tag_q     <= tag_d;
    end
  end

endmodule

// File: tb/tb_fpnew_i2fcast_pipe.sv
// Directed bench for fpnew_i2fcast_pipe: an FP32 and an FP16 instance share the input bus.
module tb_fpnew_i2fcast_pipe;

  typedef struct packed {
    logic [63:0] op;
    logic [1:0]  fmt;
    logic        mod;
    logic [2:0]  rnd;
    logic [31:0] res;
    logic [4:0]  st;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] operands = '0;
  logic [2:0]  rnd_mode = '0;
  logic        op_mod = 1'b0;
  logic [1:0]  int_fmt = 2'd2;
  logic [3:0]  tag = '0;
  logic        in_valid32 = 1'b0;
  logic        in_valid16 = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic [31:0] res32;
  logic [15:0] res16;
  logic [4:0]  st32, st16;
  logic [3:0]  tag32, tag16;
  logic        ext32, ext16, ov32, ov16, ir32, ir16, busy32, busy16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fpnew_i2fcast_pipe #(.DstFpFormat(0), .IntFmtConfig(4'b1111), .TagType(logic [3:0])) u_fp32 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(operands), .rnd_mode_i(rnd_mode),
    .op_mod_i(op_mod), .int_fmt_i(int_fmt), .tag_i(tag), .in_valid_i(in_valid32),
    .in_ready_o(ir32), .flush_i(flush), .result_o(res32), .status_o(st32),
    .extension_bit_o(ext32), .tag_o(tag32), .out_valid_o(ov32), .out_ready_i(out_ready),
    .busy_o(busy32)
  );

  fpnew_i2fcast_pipe #(.DstFpFormat(2), .IntFmtConfig(4'b1111), .TagType(logic [3:0])) u_fp16 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(operands), .rnd_mode_i(rnd_mode),
    .op_mod_i(op_mod), .int_fmt_i(int_fmt), .tag_i(tag), .in_valid_i(in_valid16),
    .in_ready_o(ir16), .flush_i(flush), .result_o(res16), .status_o(st16),
    .extension_bit_o(ext16), .tag_o(tag16), .out_valid_o(ov16), .out_ready_i(out_ready),
    .busy_o(busy16)
  );

  // Drives one op, returns the result two edges after acceptance and whether timing held
  task automatic issue(input bit h16, input vec_t v, input logic [3:0] tg,
                       output logic [31:0] res, output logic [4:0] st,
                       output logic [3:0] tgo, output bit lat_ok);
    bit rdy, ov1, ov2;
    @(negedge clk);
    operands = v.op; int_fmt = v.fmt; op_mod = v.mod; rnd_mode = v.rnd; tag = tg;
    out_ready = 1'b1;
    if (h16) in_valid16 = 1'b1; else in_valid32 = 1'b1;
    #1 rdy = h16 ? ir16 : ir32;
    @(negedge clk);
    in_valid16 = 1'b0; in_valid32 = 1'b0;
    ov1 = h16 ? ov16 : ov32;
    @(negedge clk);
    ov2    = h16 ? ov16 : ov32;
    res    = h16 ? {16'h0, res16} : res32;
    st     = h16 ? st16 : st32;
    tgo    = h16 ? tag16 : tag32;
    lat_ok = rdy && !ov1 && ov2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ov32, busy32, res32, st32, tag32, ov16, busy16} !== '0)
      $display("FAIL reset_hold: got ov=%b busy=%b res=%h st=%b tag=%h, want all 0",
               ov32, busy32, res32, st32, tag32);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ov32, busy32, res32, st32, tag32} !== '0 || ir32 !== 1'b1)
      $display("FAIL reset_release: got ov=%b busy=%b res=%h ir=%b, want 0 0 0 1",
               ov32, busy32, res32, ir32);
    else n_pass++;
    n_checks++;
    if (ext32 !== 1'b1 || ext16 !== 1'b1)
      $display("FAIL extension_bit: got %b/%b, want 1/1", ext32, ext16);
    else n_pass++;
  endtask

  task automatic test_fp32_conv();
    vec_t vecs [11] = '{
      '{64'h00000000_FFFFFFFF, 2'd2, 1'b0, 3'd0, 32'hBF800000, 5'b00000},
      '{64'h00000000_01000001, 2'd2, 1'b0, 3'd0, 32'h4B800000, 5'b00001},
      '{64'h00000000_01000001, 2'd2, 1'b0, 3'd3, 32'h4B800001, 5'b00001},
      '{64'h00000000_01000001, 2'd2, 1'b0, 3'd1, 32'h4B800000, 5'b00001},
      '{64'h00000000_FFFFFFFF, 2'd2, 1'b1, 3'd0, 32'h4F800000, 5'b00001},
      '{64'h00000000_80000000, 2'd2, 1'b0, 3'd0, 32'hCF000000, 5'b00000},
      '{64'h00000000_00000000, 2'd2, 1'b0, 3'd0, 32'h00000000, 5'b00000},
      '{64'hFFFFFFFF_00000000, 2'd2, 1'b0, 3'd2, 32'h00000000, 5'b00000},
      '{64'h12345678_9ABCDE80, 2'd0, 1'b0, 3'd0, 32'hC3000000, 5'b00000},
      '{64'h00000000_0000FFFF, 2'd1, 1'b1, 3'd0, 32'h477FFF00, 5'b00000},
      '{64'h80000000_00000000, 2'd3, 1'b0, 3'd0, 32'hDF000000, 5'b00000}
    };
    logic [31:0] r; logic [4:0] s; logic [3:0] t; bit lat;
    for (int i = 0; i < 11; i++) begin
      issue(1'b0, vecs[i], 4'(i), r, s, t, lat);
      n_checks++;
      if (r !== vecs[i].res || s !== vecs[i].st || t !== 4'(i) || !lat)
        $display("FAIL fp32_conv[%0d]: got res=%h st=%b tag=%h lat=%b, want res=%h st=%b tag=%h lat=1",
                 i, r, s, t, lat, vecs[i].res, vecs[i].st, 4'(i));
      else n_pass++;
    end
  endtask

  task automatic test_fp16_overflow();
    vec_t vecs [4] = '{
      '{64'h00000000_00011170, 2'd2, 1'b0, 3'd0, 32'h00007C00, 5'b00101},
      '{64'h00000000_00011170, 2'd2, 1'b0, 3'd1, 32'h00007BFF, 5'b00101},
      '{64'h00000000_FFFEEE90, 2'd2, 1'b0, 3'd2, 32'h0000FC00, 5'b00101},
      '{64'h00000000_FFFEEE90, 2'd2, 1'b0, 3'd3, 32'h0000FBFF, 5'b00101}
    };
    logic [31:0] r; logic [4:0] s; logic [3:0] t; bit lat;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, vecs[i], 4'hA, r, s, t, lat);
      n_checks++;
      if (r !== vecs[i].res || s !== vecs[i].st || !lat)
        $display("FAIL fp16_overflow[%0d]: got res=%h st=%b lat=%b, want res=%h st=%b lat=1",
                 i, r, s, lat, vecs[i].res, vecs[i].st);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4] = '{32'h1, 32'h2, 32'h3, 32'hFFFFFFFF};
    logic [31:0] exp_res [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF800000};
    int acc = 0;
    int got = 0;
    logic [31:0] held = '0;
    logic [3:0]  held_tag = '0;
    bit have_held = 1'b0;
    bit stable_ok = 1'b1;
    bit dup_free = 1'b1;
    int_fmt = 2'd2; op_mod = 1'b0; rnd_mode = 3'd0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      in_valid32 = (acc < 4);
      operands   = {32'h0, vals[(acc < 4) ? acc : 3]};
      tag        = 4'(acc + 1);
      out_ready  = (c >= 5);
      #1;
      if (c == 2) begin
        n_checks++;
        if (ir32 !== 1'b0) $display("FAIL stall_in_ready: got %b, want 0", ir32);
        else n_pass++;
      end
      if (ov32 && !out_ready) begin
        if (have_held && (res32 !== held || tag32 !== held_tag)) stable_ok = 1'b0;
        held = res32; held_tag = tag32; have_held = 1'b1;
      end
      if (in_valid32 && ir32) acc++;
      if (ov32 && out_ready) begin
        n_checks++;
        if (got >= 4 || res32 !== exp_res[got] || tag32 !== 4'(got + 1))
          $display("FAIL b2b_out[%0d]: got res=%h tag=%h, want res=%h tag=%h",
                   got, res32, tag32, exp_res[got % 4], 4'(got + 1));
        else n_pass++;
        got++;
      end
    end
    @(negedge clk);
    in_valid32 = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (!(stable_ok && have_held))
      $display("FAIL stall_stable: got stable=%b seen=%b, want 1 1", stable_ok, have_held);
    else n_pass++;
    n_checks++;
    if (got != 4 || acc != 4) $display("FAIL b2b_count: got out=%0d acc=%0d, want 4 4", got, acc);
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      if (ov32 !== 1'b0) dup_free = 1'b0;
    end
    n_checks++;
    if (!dup_free) $display("FAIL b2b_dup: got extra out_valid, want none");
    else n_pass++;
  endtask

  task automatic test_flush();
    bit quiet = 1'b1;
    out_ready = 1'b0; int_fmt = 2'd2; op_mod = 1'b0; rnd_mode = 3'd0;
    @(negedge clk); in_valid32 = 1'b1; operands = 64'd5; tag = 4'h5;
    @(negedge clk); operands = 64'd6; tag = 4'h6;
    @(negedge clk);
    n_checks++;
    if (ov32 !== 1'b1 || busy32 !== 1'b1)
      $display("FAIL flush_pre: got ov=%b busy=%b, want 1 1", ov32, busy32);
    else n_pass++;
    flush = 1'b1; operands = 64'd7; tag = 4'h7;
    @(negedge clk);
    flush = 1'b0; in_valid32 = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (ov32 !== 1'b0 || busy32 !== 1'b0)
      $display("FAIL flush_clear: got ov=%b busy=%b, want 0 0", ov32, busy32);
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      if (ov32 !== 1'b0 || busy32 !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL flush_no_accept: got later activity, want none");
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    vec_t v = '{64'h00000000_00000003, 2'd2, 1'b0, 3'd0, 32'h40400000, 5'b00000};
    logic [31:0] r; logic [4:0] s; logic [3:0] t; bit lat;
    out_ready = 1'b1;
    @(negedge clk); in_valid32 = 1'b1; operands = 64'd9; tag = 4'h9;
    @(negedge clk); in_valid32 = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (ov32 !== 1'b1) $display("FAIL rst_mid_pre: got ov=%b, want 1", ov32);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov32 !== 1'b0 || busy32 !== 1'b0)
      $display("FAIL rst_mid_async: got ov=%b busy=%b, want 0 0", ov32, busy32);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    issue(1'b0, v, 4'hC, r, s, t, lat);
    n_checks++;
    if (r !== v.res || s !== v.st || t !== 4'hC || !lat)
      $display("FAIL rst_mid_after: got res=%h st=%b tag=%h lat=%b, want res=%h st=%b tag=c lat=1",
               r, s, t, lat, v.res, v.st);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fp32_conv();
    test_fp16_overflow();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
